// File: rtl/datapath_mc_if.sv
// Control and status bundle between the control FSM (master) and the datapath (slave).
// The control FSM drives the load, gate and mux selects; the datapath returns register contents and multiplier status.
interface datapath_mc_if #(
    parameter int WIDTH = 16
);
    logic             LD_MAR;
    logic             LD_MDR;
    logic             LD_IR;
    logic             LD_BEN;
    logic             LD_CC;
    logic             LD_REG;
    logic             LD_PC;
    logic             GatePC;
    logic             GateMDR;
    logic             GateALU;
    logic             GateMARMUX;
    logic [1:0]       PCMUX;
    logic [1:0]       ADDR2MUX;
    logic             ADDR1MUX;
    logic             DRMUX;
    logic             SR1MUX;
    logic             SR2MUX;
    logic [2:0]       ALUK;
    logic             ALU_Start;
    logic             MIO_EN;
    logic [WIDTH-1:0] MDR_In;
    logic [WIDTH-1:0] MAR;
    logic [WIDTH-1:0] MDR;
    logic [WIDTH-1:0] IR;
    logic [WIDTH-1:0] PC;
    logic [2:0]       NZP;
    logic             BEN;
    logic             ALU_Busy;
    logic             ALU_Done;

    modport master (
        output LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC,
        output GatePC, GateMDR, GateALU, GateMARMUX,
        output PCMUX, ADDR2MUX, ADDR1MUX, DRMUX, SR1MUX, SR2MUX, ALUK,
        output ALU_Start, MIO_EN, MDR_In,
        input  MAR, MDR, IR, PC, NZP, BEN, ALU_Busy, ALU_Done
    );

    modport slave (
        input  LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC,
        input  GatePC, GateMDR, GateALU, GateMARMUX,
        input  PCMUX, ADDR2MUX, ADDR1MUX, DRMUX, SR1MUX, SR2MUX, ALUK,
        input  ALU_Start, MIO_EN, MDR_In,
        output MAR, MDR, IR, PC, NZP, BEN, ALU_Busy, ALU_Done
    );
endinterface

// File: rtl/datapath_mc.sv
// LC-3-style WIDTH-bit datapath with a shift-add multiplier; single-cycle register loads, MUL done WIDTH+1 edges after start.
// No backpressure: the control FSM sequences everything; ALU_Start while the multiplier is busy is dropped.
module datapath_mc #(
    parameter int WIDTH = 16,
    parameter int NREG  = 8
) (
    input  logic         Clk,
    input  logic         Reset,
    datapath_mc_if.slave dp
);
    if (WIDTH < 16 || NREG != 8) begin : g_bad_param
        $error("datapath_mc: WIDTH must be >= 16 and NREG must be 8");
    end

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        MUL_IDLE,
        MUL_RUN,
        MUL_DONE
    } mul_state_e;

    logic [WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0] mar_q, mar_d;
    logic [WIDTH-1:0] mdr_q, mdr_d;
    logic [WIDTH-1:0] ir_q, ir_d;
    logic [WIDTH-1:0] rf_q [NREG];
    logic [WIDTH-1:0] rf_d [NREG];
    logic [2:0]       nzp_q, nzp_d;
    logic             ben_q, ben_d;

    mul_state_e       state_q, state_d;
    logic [WIDTH-1:0] mul_a_q, mul_a_d;
    logic [WIDTH-1:0] mul_b_q, mul_b_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic [2:0]       sr1_idx, sr2_idx, dr_idx;
    logic [WIDTH-1:0] sr1_val, sr2mux_val;
    logic [WIDTH-1:0] sext5, sext6, sext9, sext11;
    logic [WIDTH-1:0] addr1_val, addr2_val, addr_sum;
    logic [WIDTH-1:0] alu_val, bus_val, pc_next;
    logic             mul_start;
    logic             unused_ir;

    assign unused_ir = ^ir_q[WIDTH-1:12];

    assign sext5  = {{(WIDTH-5){ir_q[4]}},   ir_q[4:0]};
    assign sext6  = {{(WIDTH-6){ir_q[5]}},   ir_q[5:0]};
    assign sext9  = {{(WIDTH-9){ir_q[8]}},   ir_q[8:0]};
    assign sext11 = {{(WIDTH-11){ir_q[10]}}, ir_q[10:0]};

    always_comb begin
        sr1_idx    = dp.SR1MUX ? ir_q[8:6] : ir_q[11:9];
        sr2_idx    = ir_q[2:0];
        dr_idx     = dp.DRMUX ? ir_q[11:9] : 3'd7;
        sr1_val    = rf_q[sr1_idx];
        sr2mux_val = dp.SR2MUX ? sext5 : rf_q[sr2_idx];
        addr1_val  = dp.ADDR1MUX ? sr1_val : pc_q;
        case (dp.ADDR2MUX)
            2'd0:    addr2_val = '0;
            2'd1:    addr2_val = sext6;
            2'd2:    addr2_val = sext9;
            default: addr2_val = sext11;
        endcase
        addr_sum = addr1_val + addr2_val;
        case (dp.ALUK)
            3'd0:    alu_val = sr1_val + sr2mux_val;
            3'd1:    alu_val = sr1_val & sr2mux_val;
            3'd2:    alu_val = ~sr1_val;
            3'd4:    alu_val = res_q;
            default: alu_val = sr1_val;
        endcase
        if (dp.GateMARMUX)   bus_val = addr_sum;
        else if (dp.GatePC)  bus_val = pc_q;
        else if (dp.GateALU) bus_val = alu_val;
        else if (dp.GateMDR) bus_val = mdr_q;
        else                 bus_val = '0;
        case (dp.PCMUX)
            2'd0:    pc_next = pc_q + 1'b1;
            2'd1:    pc_next = addr_sum;
            2'd2:    pc_next = bus_val;
            default: pc_next = {{(WIDTH-1){1'b0}}, 1'b1};
        endcase
    end

    always_comb begin
        pc_d  = dp.LD_PC  ? pc_next : pc_q;
        mar_d = dp.LD_MAR ? bus_val : mar_q;
        mdr_d = mdr_q;
        if (dp.LD_MDR) mdr_d = dp.MIO_EN ? dp.MDR_In : bus_val;
        ir_d  = dp.LD_IR  ? bus_val : ir_q;
        rf_d  = rf_q;
        if (dp.LD_REG) rf_d[dr_idx] = bus_val;
        nzp_d = nzp_q;
        if (dp.LD_CC) begin
            if (bus_val[WIDTH-1])  nzp_d = 3'b100;
            else if (bus_val == '0) nzp_d = 3'b010;
            else                   nzp_d = 3'b001;
        end
        // BEN sees the pre-edge NZP even when LD_CC fires in the same cycle.
        ben_d = dp.LD_BEN ? |(ir_q[11:9] & nzp_q) : ben_q;
    end

    assign mul_start = dp.ALU_Start && (dp.ALUK == 3'd4);

    always_comb begin
        state_d = state_q;
        mul_a_d = mul_a_q;
        mul_b_d = mul_b_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        case (state_q)
            MUL_RUN: begin
                if (cnt_q == CW'(WIDTH)) begin
                    res_d   = acc_q;
                    state_d = MUL_DONE;
                end else begin
                    if (mul_b_q[0]) acc_d = acc_q + mul_a_q;
                    mul_a_d = mul_a_q << 1;
                    mul_b_d = mul_b_q >> 1;
                    cnt_d   = cnt_q + 1'b1;
                end
            end
            default: begin
                // DONE falls back to IDLE but may also take a start on its final edge.
                state_d = MUL_IDLE;
                if (mul_start) begin
                    mul_a_d = sr1_val;
                    mul_b_d = sr2mux_val;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = MUL_RUN;
                end
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            pc_q    <= '0;
            mar_q   <= '0;
            mdr_q   <= '0;
            ir_q    <= '0;
            for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
            nzp_q   <= 3'b010;
            ben_q   <= 1'b0;
            state_q <= MUL_IDLE;
            mul_a_q <= '0;
            mul_b_q <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            res_q   <= '0;
        end else begin
            pc_q    <= pc_d;
            mar_q   <= mar_d;
            mdr_q   <= mdr_d;
            ir_q    <= ir_d;
            rf_q    <= rf_d;
            nzp_q   <= nzp_d;
            ben_q   <= ben_d;
            state_q <= state_d;
            mul_a_q <= mul_a_d;
            mul_b_q <= mul_b_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
        end
    end

    assign dp.MAR      = mar_q;
    assign dp.MDR      = mdr_q;
    assign dp.IR       = ir_q;
    assign dp.PC       = pc_q;
    assign dp.NZP      = nzp_q;
    assign dp.BEN      = ben_q;
    assign dp.ALU_Busy = (state_q != MUL_IDLE);
    assign dp.ALU_Done = (state_q == MUL_DONE);
endmodule

// File: tb/tb_datapath_mc.sv
// Directed bench for datapath_mc at WIDTH=16: reset, ALU/CC, branch, multiplier timing/abort, PC and bus priority.
module tb_datapath_mc;
    localparam int W = 16;

    logic Clk = 1'b0;
    logic Reset;
    int   n_chk = 0;
    int   n_bad = 0;

    datapath_mc_if #(.WIDTH(W)) dp ();

    datapath_mc #(.WIDTH(W), .NREG(8)) u_dut (
        .Clk   (Clk),
        .Reset (Reset),
        .dp    (dp)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic clr();
        dp.LD_MAR = 0; dp.LD_MDR = 0; dp.LD_IR = 0; dp.LD_BEN = 0;
        dp.LD_CC = 0; dp.LD_REG = 0; dp.LD_PC = 0;
        dp.GatePC = 0; dp.GateMDR = 0; dp.GateALU = 0; dp.GateMARMUX = 0;
        dp.PCMUX = 0; dp.ADDR2MUX = 0; dp.ADDR1MUX = 0; dp.DRMUX = 0;
        dp.SR1MUX = 0; dp.SR2MUX = 0; dp.ALUK = 0; dp.ALU_Start = 0;
        dp.MIO_EN = 0; dp.MDR_In = '0;
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic load_mdr(input logic [W-1:0] v);
        clr(); dp.MIO_EN = 1; dp.MDR_In = v; dp.LD_MDR = 1; step(); clr();
    endtask

    task automatic load_ir(input logic [W-1:0] v);
        load_mdr(v);
        dp.GateMDR = 1; dp.LD_IR = 1; step(); clr();
    endtask

    task automatic set_reg(input int r, input logic [W-1:0] v, input logic cc);
        load_ir(W'(r << 9));
        load_mdr(v);
        dp.GateMDR = 1; dp.DRMUX = 1; dp.LD_REG = 1; dp.LD_CC = cc; step(); clr();
    endtask

    // Register value appears in MAR through ALU pass-through.
    task automatic read_reg(input int r, output logic [W-1:0] v);
        load_ir(W'(r << 6));
        dp.SR1MUX = 1; dp.ALUK = 3'd3; dp.GateALU = 1; dp.LD_MAR = 1; step(); clr();
        v = dp.MAR;
    endtask

    task automatic run_mul(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [W-1:0] exp);
        logic [W-1:0] v;
        bit           seen;
        set_reg(1, a, 1'b0);
        set_reg(2, b, 1'b0);
        load_ir(16'h0642);
        dp.SR1MUX = 1; dp.ALUK = 3'd4; dp.ALU_Start = 1; step();
        dp.ALU_Start = 0;
        seen = 0;
        for (int k = 0; k < 40 && !seen; k++) begin
            step();
            if (dp.ALU_Done) seen = 1;
        end
        chk({tag, "_done_seen"}, 32'(seen), 32'd1);
        step();
        dp.ALUK = 3'd4; dp.GateALU = 1; dp.DRMUX = 1; dp.LD_REG = 1; step(); clr();
        read_reg(3, v);
        chk({tag, "_result"}, 32'(v), 32'(exp));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] v;
        int           done_cnt;
        int           done_at;
        logic         busy_mid;
        logic         busy_last;
        logic         busy_after;

        clr();
        Reset = 1'b1;
        step();
        // Reset with every load and gate asserted.
        dp.LD_MAR = 1; dp.LD_MDR = 1; dp.LD_IR = 1; dp.LD_BEN = 1; dp.LD_CC = 1;
        dp.LD_REG = 1; dp.LD_PC = 1; dp.GatePC = 1; dp.MIO_EN = 1; dp.MDR_In = 16'hBEEF;
        dp.PCMUX = 2'd3;
        step();
        Reset = 1'b0;
        clr();
        chk("rst_mar", 32'(dp.MAR), 32'h0);
        chk("rst_mdr", 32'(dp.MDR), 32'h0);
        chk("rst_ir", 32'(dp.IR), 32'h0);
        chk("rst_pc", 32'(dp.PC), 32'h0);
        chk("rst_nzp", 32'(dp.NZP), 32'b010);
        chk("rst_ben", 32'(dp.BEN), 32'h0);
        chk("rst_busy", 32'(dp.ALU_Busy), 32'h0);
        chk("rst_done", 32'(dp.ALU_Done), 32'h0);
        read_reg(5, v);
        chk("rst_r5", 32'(v), 32'h0);

        // ADD wrap: R1 = FFFF (CC negative), R2 = R1 + 1 -> 0 (CC zero).
        set_reg(1, 16'hFFFF, 1'b1);
        chk("cc_neg", 32'(dp.NZP), 32'b100);
        load_ir(16'h0441);
        dp.SR1MUX = 1; dp.SR2MUX = 1; dp.ALUK = 3'd0; dp.GateALU = 1;
        dp.DRMUX = 1; dp.LD_REG = 1; dp.LD_CC = 1; step(); clr();
        chk("add_cc_zero", 32'(dp.NZP), 32'b010);
        read_reg(2, v);
        chk("add_wrap_r2", 32'(v), 32'h0);

        // AND with register operand: R1 & R1 = FFFF.
        load_ir(16'h0841);
        dp.SR1MUX = 1; dp.ALUK = 3'd1; dp.GateALU = 1; dp.LD_MAR = 1; step(); clr();
        chk("and_rr", 32'(dp.MAR), 32'hFFFF);

        // Branch enable.
        load_ir(16'h0400);
        dp.LD_BEN = 1; step(); clr();
        chk("ben_z_taken", 32'(dp.BEN), 32'h1);
        load_mdr(16'hFFFF);
        dp.GateMDR = 1; dp.LD_CC = 1; step(); clr();
        chk("cc_neg2", 32'(dp.NZP), 32'b100);
        dp.LD_BEN = 1; step(); clr();
        chk("ben_n_not_taken", 32'(dp.BEN), 32'h0);
        load_mdr(16'h0000);
        dp.GateMDR = 1; dp.LD_CC = 1; dp.LD_BEN = 1; step(); clr();
        chk("cc_ben_same_nzp", 32'(dp.NZP), 32'b010);
        chk("cc_ben_same_ben", 32'(dp.BEN), 32'h0);

        // Multiply 3 x 5 with full timing check and an ignored restart at edge 5.
        set_reg(1, 16'h0003, 1'b0);
        set_reg(2, 16'h0005, 1'b0);
        load_ir(16'h0642);
        dp.SR1MUX = 1; dp.ALUK = 3'd4; dp.ALU_Start = 1; step();
        dp.ALU_Start = 0;
        chk("mul_busy_e0", 32'(dp.ALU_Busy), 32'h1);
        done_cnt = 0; done_at = -1; busy_mid = 0; busy_last = 0; busy_after = 1;
        for (int k = 1; k <= W + 4; k++) begin
            dp.ALU_Start = (k == 5);
            step();
            if (dp.ALU_Done) begin
                done_cnt++;
                done_at = k;
            end
            if (k == 8)     busy_mid   = dp.ALU_Busy;
            if (k == W + 1) busy_last  = dp.ALU_Busy;
            if (k == W + 2) busy_after = dp.ALU_Busy;
        end
        dp.ALU_Start = 0;
        chk("mul_done_count", 32'(done_cnt), 32'd1);
        chk("mul_done_cycle", 32'(done_at), 32'(W + 1));
        chk("mul_busy_mid", 32'(busy_mid), 32'h1);
        chk("mul_busy_done", 32'(busy_last), 32'h1);
        chk("mul_busy_fall", 32'(busy_after), 32'h0);
        dp.ALUK = 3'd4; dp.GateALU = 1; dp.DRMUX = 1; dp.LD_REG = 1; step(); clr();
        read_reg(3, v);
        chk("mul_3x5", 32'(v), 32'h000F);

        run_mul("mul_ovf", 16'h0100, 16'h0100, 16'h0000);
        run_mul("mul_neg", 16'hFFFF, 16'h0002, 16'hFFFE);
        run_mul("mul_7x9", 16'h0007, 16'h0009, 16'h003F);

        // Abort a multiply with reset at edge 8.
        set_reg(1, 16'h0007, 1'b0);
        set_reg(2, 16'h0009, 1'b0);
        load_ir(16'h0642);
        dp.SR1MUX = 1; dp.ALUK = 3'd4; dp.ALU_Start = 1; step();
        dp.ALU_Start = 0;
        for (int k = 1; k < 8; k++) step();
        Reset = 1'b1; step(); Reset = 1'b0;
        chk("abort_busy", 32'(dp.ALU_Busy), 32'h0);
        done_cnt = 0;
        for (int k = 0; k < W + 6; k++) begin
            step();
            if (dp.ALU_Done) done_cnt++;
        end
        chk("abort_no_done", 32'(done_cnt), 32'd0);
        dp.ALUK = 3'd4; dp.GateALU = 1; dp.LD_MAR = 1; step(); clr();
        chk("abort_result", 32'(dp.MAR), 32'h0);

        // PC paths.
        load_mdr(16'hFFFF);
        dp.GateMDR = 1; dp.PCMUX = 2'd2; dp.LD_PC = 1; step(); clr();
        chk("pc_from_bus", 32'(dp.PC), 32'hFFFF);
        dp.PCMUX = 2'd0; dp.LD_PC = 1; step(); clr();
        chk("pc_inc_wrap", 32'(dp.PC), 32'h0000);
        dp.PCMUX = 2'd3; dp.LD_PC = 1; step(); clr();
        chk("pc_const1", 32'(dp.PC), 32'h0001);
        dp.PCMUX = 2'd0; dp.LD_PC = 1; step(); clr();
        chk("pc_inc", 32'(dp.PC), 32'h0002);

        // Bus: idle bus, PC over MDR, MARMUX over everything.
        dp.GatePC = 1; dp.LD_MAR = 1; step(); clr();
        chk("mar_from_pc", 32'(dp.MAR), 32'h0002);
        dp.LD_MAR = 1; step(); clr();
        chk("bus_idle_zero", 32'(dp.MAR), 32'h0000);
        dp.GatePC = 1; dp.GateMDR = 1; dp.LD_MAR = 1; step(); clr();
        chk("bus_pc_over_mdr", 32'(dp.MAR), 32'h0002);
        load_ir(16'h0005);
        dp.GateMARMUX = 1; dp.GatePC = 1; dp.GateMDR = 1; dp.ADDR2MUX = 2'd1;
        dp.LD_MAR = 1; step(); clr();
        chk("marmux_pc_plus5", 32'(dp.MAR), 32'h0007);
        load_ir(16'h003F);
        dp.GateMARMUX = 1; dp.ADDR2MUX = 2'd1; dp.LD_MAR = 1; step(); clr();
        chk("marmux_pc_minus1", 32'(dp.MAR), 32'h0001);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
